// File: rtl/multicycle_seq_if.sv
// Shared memory-port handshake between the multicycle sequencer
// (master) and the memory (slave).
interface multicycle_seq_if;
    logic mem_req;
    logic mem_we;
    logic IorD;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output IorD,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  IorD,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_seq.sv
// Multicycle IF/ID/EX/MEM/WB sequencer: times the datapath strobes
// and the shared memory port, and counts retired instructions.
module multicycle_seq #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_seq_if.master mem,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    output logic             IRWr,
    output logic             PCWr,
    output logic             RFWr_en,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt
);
    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_ALU   = 3'd1;
    localparam logic [2:0] C_LOAD  = 3'd2;
    localparam logic [2:0] C_STORE = 3'd3;
    localparam logic [2:0] C_BR    = 3'd4;
    localparam logic [2:0] C_LINK  = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       r_cls;
    logic [CNT_W-1:0] r_cnt;

    logic [2:0] w_cls;
    logic [2:0] w_next;
    logic       w_req;
    logic       w_we;
    logic       w_iord;
    logic       w_irwr;
    logic       w_pcwr;
    logic       w_rfwr;

    always_comb begin
        w_cls = C_NOP;
        case (op)
            6'b000000: begin
                if (funct == 6'b001000)
                    w_cls = C_BR;
                else if (funct == 6'b001001)
                    w_cls = C_LINK;
                else
                    w_cls = C_ALU;
            end
            6'b000001, 6'b000010, 6'b000100,
            6'b000101, 6'b000110, 6'b000111:
                w_cls = C_BR;
            6'b000011:
                w_cls = C_LINK;
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111:
                w_cls = C_ALU;
            6'b100000, 6'b100001, 6'b100011,
            6'b100100, 6'b100101:
                w_cls = C_LOAD;
            6'b101000, 6'b101001, 6'b101011:
                w_cls = C_STORE;
            default:
                w_cls = C_NOP;
        endcase
    end

    always_comb begin
        w_next = S_IF;
        w_req  = 1'b0;
        w_we   = 1'b0;
        w_iord = 1'b0;
        w_irwr = 1'b0;
        w_pcwr = 1'b0;
        w_rfwr = 1'b0;
        case (r_state)
            S_IF: begin
                w_req = 1'b1;
                if (mem.mem_ready) begin
                    w_irwr = 1'b1;
                    w_next = S_ID;
                end else begin
                    w_next = S_IF;
                end
            end
            S_ID: w_next = S_EX;
            S_EX: begin
                case (r_cls)
                    C_ALU, C_LINK:   w_next = S_WB;
                    C_LOAD, C_STORE: w_next = S_MEM;
                    default:         w_pcwr = 1'b1;
                endcase
            end
            S_MEM: begin
                w_req  = 1'b1;
                w_iord = 1'b1;
                w_we   = (r_cls == C_STORE);
                if (!mem.mem_ready)
                    w_next = S_MEM;
                else if (r_cls == C_LOAD)
                    w_next = S_WB;
                else
                    w_pcwr = 1'b1;
            end
            S_WB: begin
                w_rfwr = 1'b1;
                w_pcwr = 1'b1;
            end
            default: w_next = S_IF;
        endcase
    end

    // Class is latched leaving ID so later op/funct changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IF;
            r_cls   <= C_NOP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID)
                r_cls <= w_cls;
            if (w_pcwr)
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Every strobe is forced low while reset is held.
    assign mem.mem_req = w_req  & ~rst;
    assign mem.mem_we  = w_we   & ~rst;
    assign mem.IorD    = w_iord & ~rst;
    assign IRWr        = w_irwr & ~rst;
    assign PCWr        = w_pcwr & ~rst;
    assign retire      = w_pcwr & ~rst;
    assign RFWr_en     = w_rfwr & ~rst;
    assign state       = r_state;
    assign instr_cnt   = r_cnt;
endmodule

// File: tb/tb_multicycle_seq.sv
// Scoreboard bench for multicycle_seq: the driver pushes expected
// state traces and per-instruction strobe totals, a monitor checks.
module tb_multicycle_seq;
    localparam int CW = 4;

    localparam int K_NOP   = 0;
    localparam int K_ALU   = 1;
    localparam int K_LOAD  = 2;
    localparam int K_STORE = 3;
    localparam int K_BR    = 4;
    localparam int K_LINK  = 5;

    typedef struct {
        int rf;
        int we;
        int iord;
        int cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic          IRWr;
    logic          PCWr;
    logic          RFWr_en;
    logic [2:0]    state;
    logic          retire;
    logic [CW-1:0] instr_cnt;

    multicycle_seq_if mif ();

    multicycle_seq #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (mif),
        .op        (op),
        .funct     (funct),
        .IRWr      (IRWr),
        .PCWr      (PCWr),
        .RFWr_en   (RFWr_en),
        .state     (state),
        .retire    (retire),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;
    bit   idle    = 1'b1;
    int   st_q[$];
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    function automatic int classify(logic [5:0] o, logic [5:0] f);
        logic [2:0] hi;
        hi = o[5:3];
        if (o == 6'h00)
            return (f == 6'h08) ? K_BR : (f == 6'h09) ? K_LINK : K_ALU;
        if (o inside {6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07})
            return K_BR;
        if (o == 6'h03)
            return K_LINK;
        if (hi == 3'b001)
            return K_ALU;
        if (o inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25})
            return K_LOAD;
        if (o inside {6'h28, 6'h29, 6'h2b})
            return K_STORE;
        return K_NOP;
    endfunction

    // Issue one instruction: queue its expected trace, then play memory.
    task automatic issue(input logic [5:0] o, input logic [5:0] f,
                         input int ifw, input int mw, input bit scr);
        int   k;
        bit   has_mem;
        exp_t e;
        int   fs;
        int   ds;
        int   after;
        bit   done;
        k       = classify(o, f);
        has_mem = (k == K_LOAD) || (k == K_STORE);
        e.rf    = (k == K_ALU || k == K_LINK || k == K_LOAD) ? 1 : 0;
        e.we    = (k == K_STORE) ? mw + 1 : 0;
        e.iord  = has_mem ? mw + 1 : 0;
        e.cnt   = exp_cnt;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        for (int i = 0; i <= ifw; i++) st_q.push_back(0);
        st_q.push_back(1);
        st_q.push_back(2);
        if (has_mem)
            for (int i = 0; i <= mw; i++) st_q.push_back(3);
        if (e.rf != 0) st_q.push_back(4);
        exp_q.push_back(e);
        op    = o;
        funct = f;
        fs    = 0;
        ds    = 0;
        after = 0;
        done  = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk);
            #1;
            if (scr && after == 2) begin
                op    = 6'($urandom);
                funct = 6'($urandom);
            end
            if (after > 0) after++;
            if (mif.mem_req && !mif.IorD) begin
                mif.mem_ready = (fs == ifw);
                if (fs == ifw) after = 1;
                fs++;
            end else if (mif.mem_req) begin
                mif.mem_ready = (ds == mw);
                ds++;
            end else begin
                mif.mem_ready = 1'($urandom);
            end
            @(negedge clk);
            done = retire;
        end
        if (!done) begin
            chk("retire_timeout", 32'd0, 32'd1);
            finish_run();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(mif.mem_req), 0);
        chk({tag, "_mem_we"}, 32'(mif.mem_we), 0);
        chk({tag, "_IorD"}, 32'(mif.IorD), 0);
        chk({tag, "_IRWr"}, 32'(IRWr), 0);
        chk({tag, "_PCWr"}, 32'(PCWr), 0);
        chk({tag, "_RFWr_en"}, 32'(RFWr_en), 0);
        chk({tag, "_retire"}, 32'(retire), 0);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_instr_cnt"}, 32'(instr_cnt), 0);
    endtask

    // Monitor: per-cycle state trace, per-instruction strobe totals.
    int   a_irwr, a_pcwr, a_rf, a_we, a_iord;
    int   es;
    exp_t ee;
    initial begin
        a_irwr = 0; a_pcwr = 0; a_rf = 0; a_we = 0; a_iord = 0;
        forever begin
            @(negedge clk);
            if (rst || idle) begin
                a_irwr = 0; a_pcwr = 0; a_rf = 0; a_we = 0; a_iord = 0;
                continue;
            end
            if (st_q.size() == 0) begin
                chk("state_trace_empty", 32'(state), 32'hffff_ffff);
            end else begin
                es = st_q.pop_front();
                chk("state", 32'(state), es);
            end
            chk("we_without_req", 32'(mif.mem_we & ~mif.mem_req), 0);
            chk("pcwr_vs_retire", 32'(PCWr), 32'(retire));
            a_irwr += int'(IRWr);
            a_pcwr += int'(PCWr);
            a_rf   += int'(RFWr_en);
            a_we   += int'(mif.mem_we);
            a_iord += int'(mif.IorD);
            if (retire) begin
                if (exp_q.size() == 0) begin
                    chk("retire_unexpected", 32'd1, 32'd0);
                end else begin
                    ee = exp_q.pop_front();
                    chk("rfwr_cycles", a_rf, ee.rf);
                    chk("mem_we_cycles", a_we, ee.we);
                    chk("iord_cycles", a_iord, ee.iord);
                    chk("irwr_cycles", a_irwr, 1);
                    chk("pcwr_cycles", a_pcwr, 1);
                    chk("instr_cnt", 32'(instr_cnt), ee.cnt);
                    chk("trace_left", st_q.size(), 0);
                end
                a_irwr = 0; a_pcwr = 0; a_rf = 0; a_we = 0; a_iord = 0;
            end
        end
    end

    initial begin
        rst           = 1'b1;
        op            = 6'h00;
        funct         = 6'h00;
        mif.mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst           = 1'b0;
        mif.mem_ready = 1'b0;
        #1;
        chk("post_reset_mem_req", 32'(mif.mem_req), 1);
        @(negedge clk);
        #1;
        idle = 1'b0;

        issue(6'h08, 6'h00, 0, 0, 0);
        issue(6'h23, 6'h00, 2, 3, 0);
        issue(6'h2b, 6'h00, 0, 0, 0);
        issue(6'h04, 6'h00, 0, 0, 0);
        issue(6'h02, 6'h00, 0, 0, 0);
        issue(6'h00, 6'h08, 0, 0, 0);
        issue(6'h3f, 6'h00, 0, 0, 0);
        issue(6'h03, 6'h00, 0, 0, 0);
        issue(6'h00, 6'h09, 0, 0, 0);
        issue(6'h00, 6'h08, 1, 0, 1);
        issue(6'h29, 6'h00, 1, 2, 1);

        for (int n = 0; n < 300; n++)
            issue(6'($urandom), 6'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom));

        // Abort a load mid-access with reset.
        idle  = 1'b1;
        op    = 6'h23;
        funct = 6'h00;
        for (int c = 0; c < 20 && state != 3'd3; c++) begin
            @(posedge clk);
            #1;
            mif.mem_ready = mif.mem_req && !mif.IorD;
        end
        mif.mem_ready = 1'b0;
        chk("abort_in_mem", 32'(state), 3);
        chk("abort_mem_req", 32'(mif.mem_req), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        st_q.delete();
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_release_mem_req", 32'(mif.mem_req), 1);
        chk("abort_release_IorD", 32'(mif.IorD), 0);
        @(negedge clk);
        #1;
        idle = 1'b0;

        for (int n = 0; n < 16; n++)
            issue((n % 2 == 0) ? 6'h3f : 6'h10, 6'h00, n % 2, 0, 0);
        idle = 1'b1;
        @(posedge clk);
        #1;
        chk("counter_wrap", 32'(instr_cnt), exp_cnt);
        chk("counter_wrap_zero", 32'(instr_cnt), 0);
        finish_run();
    end
endmodule

// File: doc/multicycle_seq.md
# multicycle_seq

Multicycle sequencer for the MIPS datapath: it steps each instruction through IF, ID, EX, MEM and WB over several clock cycles, so one memory port can serve both instruction fetch and data access. The existing combinational decoder stays in place and still produces RegDst, ToReg, ALUSrc, ALUOp, NPCOp, DMWr and DMRe. This block decides *when* those signals take effect by driving the write enables, the memory request handshake and the address mux select. It also keeps a retired-instruction counter.

## Interface
- CNT_W, 32, width of the retired-instruction counter.
- clk  in  1  system clock; rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op  in  6  IR[31:26]; only meaningful from ID onward.
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory completion; sampled only while mem_req=1.
- mem_req  out  1  shared memory port request.
- mem_we  out  1  memory write enable, qualifies mem_req.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- IRWr  out  1  IR load strobe.
- PCWr  out  1  PC load strobe; PC takes the NPC output.
- RFWr_en  out  1  register file write gate; ANDed with the decoder's RFWr.
- state  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4.
- retire  out  1  one-cycle pulse when an instruction completes.
- instr_cnt  out  CNT_W  count of retired instructions.

## Operation
- **Instruction class.** Class is decoded from op/funct and registered at the ID→EX edge. It is held until the next ID.
  - ALU: R-type except JR/JALR, ADDI, ADDIU, ANDI, LUI, ORI, SLTI, SLTIU, XORI.
  - LOAD: LB, LH, LW, LBU, LHU (op 100000, 100001, 100011, 100100, 100101).
  - STORE: SB, SH, SW (op 101000, 101001, 101011).
  - BR: BEQ, BNE, BLEZ, BGTZ, op 000001, J, and JR (op 000000, funct 001000).
  - LINK: JAL (op 000011) and JALR (op 000000, funct 001001).
  - NOP: any other opcode.
- **IF**
  - mem_req=1, IorD=0, mem_we=0.
  - On mem_ready=1: IRWr=1 for that cycle, next state ID.
  - Otherwise stay in IF.
- **ID**
  - No strobes. Next state EX.
- **EX**
  - BR or NOP: PCWr=1, retire=1, next state IF.
  - ALU or LINK: next state WB.
  - LOAD or STORE: next state MEM.
- **MEM**
  - mem_req=1, IorD=1, mem_we=1 for STORE only.
  - Stay in MEM until mem_ready=1.
  - On mem_ready with LOAD: next state WB.
  - On mem_ready with STORE: PCWr=1, retire=1, next state IF.
- **WB**
  - RFWr_en=1, PCWr=1, retire=1, next state IF.
- **Strobe rules**
  - All strobes are combinational from state, class and mem_ready.
  - mem_we is never 1 unless mem_req=1.
  - IRWr, PCWr, RFWr_en and retire are never asserted in the same cycle as rst.
- **Counter**
  - instr_cnt increments by 1 on each retire, modulo 2^CNT_W. All-ones wraps to 0.
- **mem_ready**
  - Ignored whenever mem_req=0.
  - A mem_ready held high across consecutive requests completes each request in its first cycle.

## Timing
- **Reset.** rst asynchronously forces state=IF, class=NOP and instr_cnt=0. While rst=1, every output is 0, including mem_req.
- **Leaving reset.** After rst deasserts, mem_req=1 in the first cycle.
- **Cycles per instruction** (zero-wait memory, mem_ready=1 on the first request cycle):
  - BR and NOP: 3.
  - ALU, LINK and STORE: 4.
  - LOAD: 5.
- **Wait states.** Each extra cycle mem_ready stays low adds one cycle to IF or MEM.
- **Strobe alignment.**
  - PCWr and retire are asserted in the same cycle. That cycle is the last one of the instruction.
  - The next IF begins on the following cycle.
- **Reset mid-access.** Reset during MEM (request outstanding) abandons the access with no PC, IR or register-file update. The memory must tolerate a dropped request.
- **Mid-instruction op changes.** op/funct changes after ID have no effect, because class is registered.

## Test plan
- **Reset, then ADDI, zero-wait memory.**
  - Expected state sequence: 0,1,2,4,0.
  - IRWr in cycle 1; RFWr_en, PCWr and retire in cycle 4.
  - instr_cnt goes 0→1.
- **LW with mem_ready low for 2 cycles in IF and 3 cycles in MEM.**
  - Total of 10 cycles.
  - IorD=1 only while in MEM; mem_we stays 0 throughout.
  - A single retire.
- **SW, zero-wait memory.**
  - mem_we=1 only in the MEM cycle.
  - PCWr and retire in MEM.
  - WB is never entered; RFWr_en never asserts.
- **BEQ, then J, then JR, then unknown op 111111.**
  - Each takes 3 cycles: PCWr in EX, RFWr_en never asserts.
  - instr_cnt ends at 4.
- **JAL and JALR.**
  - Both visit WB, with RFWr_en=1 and PCWr=1 in the same cycle.
  - JR (funct 001000) goes to IF directly from EX.
- **rst pulsed for 1 cycle while in MEM with mem_ready=0.**
  - Outputs go to 0 immediately, state=0, instr_cnt=0.
  - mem_req=1 again in the first cycle after rst releases.
- **Counter wrap.** With CNT_W=4, 16 NOPs bring instr_cnt back to 0.
